// File: rtl/riscv_multi_top.sv
// riscv_multi_top -- multi-cycle RV32I subset core (lw, sw, add/sub/and/or/slt,
// addi, beq, jal) built around one unified word memory and one shared ALU,
// sequenced by a controller FSM. Anything outside the subset parks the core in
// HALT until reset.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   pc           current PC register
//   instr        instruction register
//   state        controller state (FETCH 0 .. JAL 10, HALT 15)
//   alu_out      ALU result register
//   mem_addr     byte address presented to memory
//   mem_we       memory write enable (MEMWRITE only)
//   mem_wd_data  memory write data
//   mem_rd_data  combinational memory read data
//   instr_done   one-cycle pulse in the final state of each retired instruction
//   halted       high while in HALT
//
// Hierarchy rf._reg[] and mem._mem[] is kept stable so benches can preload.

// Register file: two combinational reads, one synchronous write, x0 hardwired.
// Contents are deliberately not reset.
module riscv_multi_rf (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] _reg [0:31];

  always_ff @(posedge clk)
    if (i_we && (i_wa != 5'd0)) _reg[i_wa] <= i_wd;

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : _reg[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : _reg[i_ra2];
endmodule

// Unified word memory: combinational read, synchronous write. The word index
// is taken from the low address bits only, so larger addresses wrap.
module riscv_multi_mem #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd
);
  localparam int AW = $clog2(WORDS);

  logic [31:0]   _mem [0:WORDS-1];
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_idx    = i_addr[AW+1:2];
  assign w_unused = ^{i_addr[31:AW+2], i_addr[1:0]};

  always_ff @(posedge clk)
    if (i_we) _mem[w_idx] <= i_wd;

  assign o_rd = _mem[w_idx];
endmodule

module riscv_multi_top #(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [3:0]  state,
  output logic [31:0] alu_out,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd_data,
  output logic [31:0] mem_rd_data,
  output logic        instr_done,
  output logic        halted
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd15;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;
  localparam logic [2:0] A_AND = 3'd2;
  localparam logic [2:0] A_OR  = 3'd3;
  localparam logic [2:0] A_SLT = 3'd4;

  logic [3:0]  r_state;
  logic [31:0] r_pc, r_old_pc, r_instr, r_a, r_b, r_alu_out, r_data;

  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
  logic        w_r_ok;
  logic [3:0]  w_dec_state;
  logic [31:0] w_alu_a, w_alu_b, w_alu_y;
  logic [2:0]  w_alu_op, w_r_alu_op;
  logic        w_alu_zero;
  logic [31:0] w_rd1, w_rd2, w_rf_wd, w_mem_addr, w_mem_rd;
  logic        w_rf_we, w_mem_we;

  // Instruction fields and immediates
  assign w_op    = r_instr[6:0];
  assign w_rd    = r_instr[11:7];
  assign w_f3    = r_instr[14:12];
  assign w_rs1   = r_instr[19:15];
  assign w_rs2   = r_instr[24:20];
  assign w_f7    = r_instr[31:25];
  assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
  assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                    r_instr[11:8], 1'b0};
  assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                    r_instr[30:21], 1'b0};

  // Only the five supported R-type encodings are legal
  assign w_r_ok = ((w_f7 == 7'b0000000) && ((w_f3 == 3'b000) || (w_f3 == 3'b111) ||
                                            (w_f3 == 3'b110) || (w_f3 == 3'b010))) ||
                  ((w_f7 == 7'b0100000) && (w_f3 == 3'b000));

  always_comb begin
    w_dec_state = S_HALT;
    case (w_op)
      OP_LW, OP_SW: if (w_f3 == 3'b010) w_dec_state = S_MEMADR;
      OP_R:         if (w_r_ok)         w_dec_state = S_EXECR;
      OP_ADDI:      if (w_f3 == 3'b000) w_dec_state = S_EXECI;
      OP_BEQ:       if (w_f3 == 3'b000) w_dec_state = S_BEQ;
      OP_JAL:                           w_dec_state = S_JAL;
      default:                          w_dec_state = S_HALT;
    endcase
  end

  always_comb begin
    case (w_f3)
      3'b111:  w_r_alu_op = A_AND;
      3'b110:  w_r_alu_op = A_OR;
      3'b010:  w_r_alu_op = A_SLT;
      default: w_r_alu_op = w_f7[5] ? A_SUB : A_ADD;
    endcase
  end

  // Shared ALU operand steering. BEQ reuses the subtractor for equality and
  // JAL's link value is the already-incremented PC, so one adder suffices.
  always_comb begin
    w_alu_a  = r_pc;
    w_alu_b  = 32'd4;
    w_alu_op = A_ADD;
    case (r_state)
      S_DECODE: begin w_alu_a = r_old_pc; w_alu_b = w_imm_b; end
      S_MEMADR: begin w_alu_a = r_a; w_alu_b = (w_op == OP_SW) ? w_imm_s : w_imm_i; end
      S_EXECR:  begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = w_r_alu_op; end
      S_EXECI:  begin w_alu_a = r_a; w_alu_b = w_imm_i; end
      S_BEQ:    begin w_alu_a = r_a; w_alu_b = r_b; w_alu_op = A_SUB; end
      S_JAL:    begin w_alu_a = r_old_pc; w_alu_b = w_imm_j; end
      default:  ;
    endcase
  end

  always_comb begin
    case (w_alu_op)
      A_SUB:   w_alu_y = w_alu_a - w_alu_b;
      A_AND:   w_alu_y = w_alu_a & w_alu_b;
      A_OR:    w_alu_y = w_alu_a | w_alu_b;
      A_SLT:   w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      default: w_alu_y = w_alu_a + w_alu_b;
    endcase
  end
  assign w_alu_zero = (w_alu_y == 32'd0);

  // Register writeback; in JAL r_pc already holds old_pc + 4
  assign w_rf_we = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_JAL);
  always_comb begin
    case (r_state)
      S_MEMWB: w_rf_wd = r_data;
      S_JAL:   w_rf_wd = r_pc;
      default: w_rf_wd = r_alu_out;
    endcase
  end

  assign w_mem_addr = ((r_state == S_MEMREAD) || (r_state == S_MEMWRITE)) ? r_alu_out : r_pc;
  assign w_mem_we   = (r_state == S_MEMWRITE);

  riscv_multi_rf rf (
    .clk   (clk),
    .i_we  (w_rf_we),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .i_wa  (w_rd),
    .i_wd  (w_rf_wd),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  riscv_multi_mem #(.WORDS(MEM_WORDS)) mem (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_addr (w_mem_addr),
    .i_wd   (r_b),
    .o_rd   (w_mem_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_old_pc  <= 32'd0;
      r_instr   <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
      r_data    <= 32'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_instr  <= w_mem_rd;
          r_old_pc <= r_pc;
          r_pc     <= w_alu_y;
          r_state  <= S_DECODE;
        end
        S_DECODE: begin
          r_a       <= w_rd1;
          r_b       <= w_rd2;
          r_alu_out <= w_alu_y;
          r_state   <= w_dec_state;
        end
        S_MEMADR: begin
          r_alu_out <= w_alu_y;
          r_state   <= (w_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          r_data  <= w_mem_rd;
          r_state <= S_MEMWB;
        end
        S_EXECR, S_EXECI: begin
          r_alu_out <= w_alu_y;
          r_state   <= S_ALUWB;
        end
        S_BEQ: begin
          if (w_alu_zero) r_pc <= r_alu_out;
          r_state <= S_FETCH;
        end
        S_JAL: begin
          r_pc    <= w_alu_y;
          r_state <= S_FETCH;
        end
        S_MEMWB, S_MEMWRITE, S_ALUWB: r_state <= S_FETCH;
        S_HALT:                       r_state <= S_HALT;
        default:                      r_state <= S_HALT;
      endcase
    end
  end

  assign pc          = r_pc;
  assign instr       = r_instr;
  assign state       = r_state;
  assign alu_out     = r_alu_out;
  assign mem_addr    = w_mem_addr;
  assign mem_we      = w_mem_we;
  assign mem_wd_data = r_b;
  assign mem_rd_data = w_mem_rd;
  assign instr_done  = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ) || (r_state == S_JAL);
  assign halted      = (r_state == S_HALT);
endmodule

// File: doc/riscv_multi_top.md
Name: riscv_multi_top

Overview:
Multi-cycle RV32I subset core. Successor to the single-cycle top: one unified instruction/data memory and a single shared ALU, sequenced by a controller FSM. Memory depth and reset vector are parametrised. Per-state debug outputs let benches check progress cycle by cycle. Hierarchy is fixed for bench preload: register file `dut.rf._reg[0..31]`, memory `dut.mem._mem[0..MEM_WORDS-1]`.

Parameters:
MEM_WORDS, 64, depth of unified word memory; power of two, 16..4096.
RESET_PC, 32'h0, PC loaded on reset; word aligned.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
pc  out  32  current PC register.
instr  out  32  instruction register.
state  out  4  controller state encoding (below).
alu_out  out  32  ALU result register.
mem_addr  out  32  byte address presented to memory.
mem_we  out  1  memory write enable, this cycle.
mem_wd_data  out  32  memory write data.
mem_rd_data  out  32  memory read data (combinational).
instr_done  out  1  one-cycle pulse in the final state of every retired instruction.
halted  out  1  high while in HALT.

Behaviour:
- Supported: lw, sw, R-type add/sub/and/or/slt, addi, beq, jal. Any other opcode/funct -> HALT.
- Memory: combinational read, synchronous write on clk rising edge when mem_we. Index = mem_addr[log2(MEM_WORDS)+1:2]; upper bits ignored (wrap); addr[1:0] ignored.
- Register file: 2 combinational reads, 1 synchronous write. x0 reads 0 and ignores writes. Not cleared by reset.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, HALT 15.
- FETCH: mem_addr=pc; instr<=mem; old_pc<=pc; pc<=pc+4.
- DECODE: latch A=rs1, B=rs2; alu_out<=old_pc+immB (branch target). Next state by opcode.
- MEMADR: alu_out<=A+imm (I for lw, S for sw) -> MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_addr=alu_out; data reg<=mem -> MEMWB.
- MEMWB: rd<=data reg; instr_done=1 -> FETCH.
- MEMWRITE: mem_addr=alu_out, mem_we=1, mem_wd_data=B; instr_done=1 -> FETCH.
- EXECR: alu_out<=A op B -> ALUWB. EXECI: alu_out<=A+immI -> ALUWB.
- ALUWB: rd<=alu_out; instr_done=1 -> FETCH.
- BEQ: if A==B then pc<=alu_out; instr_done=1 -> FETCH.
- JAL: rd<=old_pc+4; pc<=old_pc+immJ; instr_done=1 -> FETCH.
- Latency in cycles: lw 5; sw, R-type, addi 4; beq, jal 3.
- slt is signed. sub/add wrap mod 2^32.
- HALT: no register or memory writes; pc and instr frozen; halted=1; instr_done=0. Only reset exits.
- Reset (rst=0), asynchronous and mid-instruction included: state=FETCH, pc=RESET_PC, instr=0, alu_out=0, data/A/B/old_pc=0. Outputs: mem_we=0, instr_done=0, halted=0. The instruction in flight is aborted with no writes. FETCH of RESET_PC occurs on the first rising edge after rst rises.
- mem_we asserts only in MEMWRITE. instr_done never asserts in two consecutive cycles.

Test Plan:
- Preload x9=0x44, mem[16]=0xdeadc0de; lw x6,-4(x9) at RESET_PC=0. Release reset -> states 0,1,2,3,4; x6=0xdeadc0de after 5th edge; instr_done high only in MEMWB; pc=4.
- sw x6,8(x9) next -> mem[19]=0xdeadc0de after 4 cycles; mem_we high exactly 1 cycle; mem_addr=0x4C.
- x5=0xfffffffe, x6=0xdeadc0de: or x4,x5,x6 -> x4=0xfffffffe. slt x7,x5,x0 -> x7=1. sub x8,x0,x5 -> x8=2. Each takes 4 cycles.
- beq x4,x4,-12 at pc=12 -> pc=0 after 3 cycles. beq with unequal operands -> pc=16. jal x1,+8 at 0x10 -> x1=0x14, pc=0x18.
- Word 0x00000000 fetched -> state=15, halted=1; pc, registers and memory unchanged for 10 cycles; rst low -> pc=RESET_PC, state=0.
- Assert rst in MEMREAD of lw and in MEMWRITE of sw -> rd/memory unchanged. Re-run with RESET_PC=0x20, MEM_WORDS=16: first fetch from mem[8]; address 0x44 wraps to mem[1].
